// File: rtl/mysystem_sram_bist_master.sv
// -----------------------------------------------------------------------------
// mysystem_sram_bist_master
//   Avalon-MM master for power-on test of the on-chip SRAM. On start it writes
//   a seeded pattern (data = seed + address) over a region and reads it back
//   pipelined. It then reports pass/fail, a saturating error count and the
//   first failing address.
//
//   Handshake: the SRAM slave has no waitrequest, so every cycle with
//   avm_chipselect high is one accepted transfer (avm_write selects
//   direction). avm_readdata is valid exactly READ_LATENCY cycles after the
//   cycle in which a read was presented.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   start             begin a test (only looked at in IDLE)
//   base_addr         first word address of the region
//   length            number of words, 0..2**ADDR_W
//   seed              pattern seed
//   avm_*             Avalon-MM master signals toward the SRAM
//   busy              high in WRITE, READ and DRAIN
//   done              one-cycle completion pulse
//   pass              1 = no mismatches, valid from done until next start
//   error_count       saturating mismatch count
//   first_fail_addr   address of the first mismatch, 0 if none
//   state_dbg         current FSM state encoding
// -----------------------------------------------------------------------------
module mysystem_sram_bist_master #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1,
   parameter int ERR_W        = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W:0]       length,
   input  logic [DATA_W-1:0]     seed,
   output logic [ADDR_W-1:0]     avm_address,
   output logic [DATA_W/8-1:0]   avm_byteenable,
   output logic                  avm_chipselect,
   output logic                  avm_write,
   output logic [DATA_W-1:0]     avm_writedata,
   input  logic [DATA_W-1:0]     avm_readdata,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      error_count,
   output logic [ADDR_W-1:0]     first_fail_addr,
   output logic [2:0]            state_dbg
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(READ_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [ADDR_W-1:0]   base_q;
   logic [CNT_W-1:0]    len_q;
   logic [DATA_W-1:0]   seed_q;
   logic [CNT_W-1:0]    idx;

   logic [ADDR_W-1:0]   cur_addr;
   logic [DATA_W-1:0]   exp_data;
   logic                last_beat;

   // Expected data/address of each issued read, aligned with avm_readdata.
   logic                pipe_v [READ_LATENCY];
   logic [DATA_W-1:0]   pipe_d [READ_LATENCY];
   logic [ADDR_W-1:0]   pipe_a [READ_LATENCY];

   logic                mismatch;
   logic [ERR_W-1:0]    err_next;

   // Address wraps naturally at 2**ADDR_W through the truncating add.
   assign cur_addr  = base_q + idx[ADDR_W-1:0];
   assign exp_data  = seed_q + DATA_W'(cur_addr);
   assign last_beat = (idx == len_q - 1'b1);
   assign state_dbg = state;

   assign mismatch = pipe_v[READ_LATENCY-1] &&
                     (avm_readdata != pipe_d[READ_LATENCY-1]);
   assign err_next = (mismatch && !(&error_count)) ? error_count + 1'b1
                                                   : error_count;

   // Next state and bus outputs
   always_comb begin
      next_state     = state;
      avm_address    = '0;
      avm_byteenable = '0;
      avm_chipselect = 1'b0;
      avm_write      = 1'b0;
      avm_writedata  = '0;
      busy           = 1'b0;
      done           = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) next_state = (length == '0) ? S_DONE : S_WRITE;
         end
         S_WRITE: begin
            busy           = 1'b1;
            avm_chipselect = 1'b1;
            avm_write      = 1'b1;
            avm_byteenable = '1;
            avm_address    = cur_addr;
            avm_writedata  = exp_data;
            if (last_beat) next_state = S_READ;
         end
         S_READ: begin
            busy           = 1'b1;
            avm_chipselect = 1'b1;
            avm_byteenable = '1;
            avm_address    = cur_addr;
            if (last_beat) next_state = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (idx == DRAIN_LAST) next_state = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // State register, run parameters and beat counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         base_q <= '0;
         len_q  <= '0;
         seed_q <= '0;
         idx    <= '0;
      end else begin
         state <= next_state;
         if (state == S_IDLE && start) begin
            base_q <= base_addr;
            len_q  <= length;
            seed_q <= seed;
         end
         // Counter restarts on every phase change so each phase counts from 0.
         if (state != next_state)
            idx <= '0;
         else if (busy)
            idx <= idx + 1'b1;
      end
   end

   // Read-compare pipeline
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_d[i] <= '0;
            pipe_a[i] <= '0;
         end
      end else begin
         pipe_v[0] <= (state == S_READ);
         pipe_d[0] <= exp_data;
         pipe_a[0] <= cur_addr;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
            pipe_a[i] <= pipe_a[i-1];
         end
      end
   end

   // Results. The last compare lands in the final DRAIN cycle, so pass is
   // taken from err_next on the edge into DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         error_count     <= '0;
         first_fail_addr <= '0;
         pass            <= 1'b0;
      end else if (state == S_IDLE && start) begin
         error_count     <= '0;
         first_fail_addr <= '0;
         pass            <= (length == '0);
      end else begin
         error_count <= err_next;
         if (mismatch && error_count == '0)
            first_fail_addr <= pipe_a[READ_LATENCY-1];
         if (state == S_DRAIN && next_state == S_DONE)
            pass <= (err_next == '0);
      end
   end

endmodule
